tf_rom_loader: RTL and testbench

- Writer side of the twiddle-factor memory that the tf address generator reads.
- On a start command it accepts a stream of twiddle words over valid/ready and writes them into the region selected by opcode: NTT, INTT or PWM1.
- Write addresses are generated in the same layout the reader expects.
- Sits between the host/DMA twiddle source and the write port of the tf RAM.

---
 rtl/tf_rom_loader_pkg.sv | 33 +++
 rtl/tf_rom_loader_region_decode.sv | 34 +++
 rtl/tf_rom_loader.sv | 102 ++++++++++
 tb/tb_tf_rom_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tf_rom_loader_pkg.sv
// Shared constants and types for the twiddle-factor memory loader.
// Region layout matches what the tf address generator reads.
package tf_rom_loader_pkg;

    localparam int DATA_WIDTH     = 12;
    localparam int ADDR_ROM_WIDTH = 8;
    localparam int NTT_LEN        = 64;
    localparam int OFFSET_TF_1    = 64;
    localparam int INTT_LEN       = 64;
    localparam int OFFSET_TF_2    = 128;
    localparam int PWM1_LEN       = 128;
    localparam int Q              = 3329;

    // One extra bit so the largest region length is representable.
    localparam int LEN_WIDTH = ADDR_ROM_WIDTH + 1;

    typedef logic [ADDR_ROM_WIDTH-1:0] addr_t;
    typedef logic [LEN_WIDTH-1:0]      len_t;
    typedef logic [DATA_WIDTH-1:0]     data_t;

    typedef enum logic [1:0] {
        OP_NTT  = 2'd0,
        OP_INTT = 2'd1,
        OP_PWM1 = 2'd2
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/tf_rom_loader_region_decode.sv
// Combinational opcode decode into region base address and length.
// Opcode 3 has no region and is flagged illegal.
module tf_region_decode
    import tf_rom_loader_pkg::*;
(
    input  logic [1:0] opcode,
    output addr_t      base,
    output len_t       len,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        base    = '0;
        len     = '0;
        illegal = 1'b0;
        case (opcode)
            OP_NTT: begin
                base = '0;
                len  = LEN_WIDTH'(NTT_LEN);
            end
            OP_INTT: begin
                base = ADDR_ROM_WIDTH'(OFFSET_TF_1);
                len  = LEN_WIDTH'(INTT_LEN);
            end
            OP_PWM1: begin
                base = ADDR_ROM_WIDTH'(OFFSET_TF_2);
                len  = LEN_WIDTH'(PWM1_LEN);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/tf_rom_loader.sv
// Twiddle-factor memory writer: streams words into the NTT/INTT/PWM1 region.
// Optional range check against Q enabled by defining TF_RANGE_CHECK_EN.
module tf_rom_loader
    import tf_rom_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                opcode,
    input  logic                      din_valid,
    input  logic [DATA_WIDTH-1:0]     din,
    output logic                      din_ready,
    output logic                      we,
    output logic [ADDR_ROM_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    state_e state_q, state_d;
    addr_t  base_q, dec_base;
    len_t   len_q, dec_len, cnt_q;
    logic   dec_illegal, hs, last_word, start_ok, illegal_req, keep_word;

    tf_region_decode u_decode (
        .opcode  (opcode),
        .base    (dec_base),
        .len     (dec_len),
        .illegal (dec_illegal)
    );

    assign din_ready   = (state_q == ST_LOAD);
    assign busy        = (state_q != ST_IDLE);
    assign hs          = din_valid & din_ready;
    assign last_word   = (cnt_q == len_q - 1'b1);
    assign start_ok    = (state_q == ST_IDLE) && start && !dec_illegal;
    assign illegal_req = (state_q == ST_IDLE) && start && dec_illegal;

`ifdef TF_RANGE_CHECK_EN
    assign keep_word = (din < DATA_WIDTH'(Q));
`else
    assign keep_word = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_LOAD;
            ST_LOAD:  if (hs && last_word) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            we      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            we      <= 1'b0;
            done    <= 1'b0;

            if (start_ok) begin
                base_q <= dec_base;
                len_q  <= dec_len;
                cnt_q  <= '0;
            end

            // Out-of-range words still consume an address slot to keep the layout fixed.
            if (hs) begin
                cnt_q <= cnt_q + 1'b1;
                done  <= last_word;
                if (keep_word) begin
                    we    <= 1'b1;
                    waddr <= base_q + cnt_q[ADDR_ROM_WIDTH-1:0];
                    wdata <= din;
                end
            end

`ifdef TF_RANGE_CHECK_EN
            if (start_ok) begin
                err <= 1'b0;
            end else if (illegal_req || (hs && !keep_word)) begin
                err <= 1'b1;
            end
`else
            err <= illegal_req;
`endif
        end
    end

endmodule

// File: tb/tb_tf_rom_loader.sv
// Scoreboard bench for tf_rom_loader: expected writes queued at drive time,
// popped and compared on the negedge whenever the DUT asserts we.
module tb_tf_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  opcode = 2'd0;
    logic        din_valid = 1'b0;
    logic [11:0] din = '0;
    logic        din_ready, we, busy, done, err;
    logic [7:0]  waddr;
    logic [11:0] wdata;

    typedef struct {
        logic [7:0]  addr;
        logic [11:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;

    tf_rom_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (we) begin
                if (sb.size() == 0) begin
                    check("spurious_we_addr", {24'd0, waddr}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("waddr", {24'd0, waddr}, {24'd0, e.addr});
                    check("wdata", {20'd0, wdata}, {20'd0, e.data});
                    check("done_on_write", {31'd0, done}, {31'd0, e.last});
                end
            end else if (done) begin
                check("done_without_we", {31'd0, done}, 32'd0);
            end
            if (done) done_seen++;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full region load; bad_idx marks a word equal to Q (range-check build only).
    task automatic run_load(input logic [1:0] op, input int n, input int base, input int dbase,
                            input bit gaps, input int start_at, input int bad_idx);
        int done_before;
        done_before = done_seen;
        start  = 1'b1;
        opcode = op;
        step();
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("ready_in_load", {31'd0, din_ready}, 32'd1);
        check("err_clear_on_start", {31'd0, err}, 32'd0);
        for (int k = 0; k < n; k++) begin
            din_valid = 1'b1;
            din       = (k == bad_idx) ? 12'd3329 : 12'(dbase + k);
            if (k == start_at) begin
                start  = 1'b1;
                opcode = 2'd1;
            end
            if (k != bad_idx)
                sb.push_back('{addr: 8'(base + k), data: 12'(dbase + k), last: (k == n - 1)});
            step();
            din_valid = 1'b0;
            start     = 1'b0;
            if (gaps && k != n - 1) begin
                step();
                step();
            end
        end
        check("ready_after_last", {31'd0, din_ready}, 32'd0);
        check("busy_in_flush", {31'd0, busy}, 32'd1);
        step();
        check("busy_back_idle", {31'd0, busy}, 32'd0);
        check("we_back_idle", {31'd0, we}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);
        check("done_count", done_seen, done_before + 1);
        step();
    endtask

    initial begin
        #2;
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ready", {31'd0, din_ready}, 32'd0);
        check("rst_waddr", {24'd0, waddr}, 32'd0);
        check("rst_wdata", {20'd0, wdata}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step();

        // start together with din_valid in IDLE: the word must not be taken
        start     = 1'b1;
        opcode    = 2'd0;
        din_valid = 1'b1;
        din       = 12'd999;
        check("ready_idle", {31'd0, din_ready}, 32'd0);
        start     = 1'b0;
        din_valid = 1'b0;

        run_load(2'd0, 64, 0, 100, 1'b0, -1, -1);
        run_load(2'd1, 64, 64, 300, 1'b1, -1, -1);
        run_load(2'd2, 128, 128, 500, 1'b0, -1, -1);

        // illegal opcode
        start  = 1'b1;
        opcode = 2'd3;
        step();
        start = 1'b0;
        check("illegal_err", {31'd0, err}, 32'd1);
        check("illegal_busy", {31'd0, busy}, 32'd0);
        check("illegal_we", {31'd0, we}, 32'd0);
        step();
`ifdef TF_RANGE_CHECK_EN
        check("illegal_err_sticky", {31'd0, err}, 32'd1);
`else
        check("illegal_err_pulse", {31'd0, err}, 32'd0);
`endif
        check("illegal_busy2", {31'd0, busy}, 32'd0);

        // reset mid-load after 10 writes
        start  = 1'b1;
        opcode = 2'd0;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            din_valid = 1'b1;
            din       = 12'(700 + k);
            sb.push_back('{addr: 8'(k), data: 12'(700 + k), last: 1'b0});
            step();
        end
        din_valid = 1'b0;
        @(negedge clk);
        #1;
        din_valid = 1'b1;
        din       = 12'd999;
        rst       = 1'b0;
        #1;
        check("midrst_we", {31'd0, we}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        check("midrst_ready", {31'd0, din_ready}, 32'd0);
        check("midrst_waddr", {24'd0, waddr}, 32'd0);
        check("midrst_wdata", {20'd0, wdata}, 32'd0);
        check("midrst_sb", sb.size(), 32'd0);
        din_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        step();

        // reload from base with a start pulse ignored mid-load
        run_load(2'd0, 64, 0, 40, 1'b0, 20, -1);

`ifdef TF_RANGE_CHECK_EN
        run_load(2'd0, 64, 0, 100, 1'b0, -1, 5);
        check("range_err_sticky", {31'd0, err}, 32'd1);
        step();
        step();
        check("range_err_held", {31'd0, err}, 32'd1);
        run_load(2'd0, 64, 0, 200, 1'b0, -1, -1);
`endif

        check("final_sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
